// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared definitions for the 6502 decode stage.
//  - addressing-mode codes (ADDR_*), instruction-type codes (ITYPE_*)
//  - d_to_e_reg field positions and a word-packing helper
//  - decode_op(): documented-opcode table -> {type, mode, size}
package cpu6502_pkg;

  typedef enum logic [3:0] {
    ADDR_ILL = 4'd0, ADDR_ACC, ADDR_IMM, ADDR_ABS, ADDR_ZP, ADDR_ZPX, ADDR_ABSX,
    ADDR_IMP, ADDR_REL, ADDR_IZX, ADDR_IZY, ADDR_IND, ADDR_ZPY, ADDR_ABSY
  } addr_mode_e;

  typedef enum logic [5:0] {
    ITYPE_ILL = 6'd0,
    ITYPE_ORA, ITYPE_AND, ITYPE_EOR, ITYPE_ADC, ITYPE_STA, ITYPE_LDA, ITYPE_CMP, ITYPE_SBC,
    ITYPE_ASL, ITYPE_ROL, ITYPE_LSR, ITYPE_ROR, ITYPE_STX, ITYPE_LDX, ITYPE_DEC, ITYPE_INC,
    ITYPE_BIT, ITYPE_JMP, ITYPE_STY, ITYPE_LDY, ITYPE_CPY, ITYPE_CPX,
    ITYPE_BPL, ITYPE_BMI, ITYPE_BVC, ITYPE_BVS, ITYPE_BCC, ITYPE_BCS, ITYPE_BNE, ITYPE_BEQ,
    ITYPE_BRK, ITYPE_JSR, ITYPE_RTI, ITYPE_RTS, ITYPE_PHP, ITYPE_PLP, ITYPE_PHA, ITYPE_PLA,
    ITYPE_DEY, ITYPE_TAY, ITYPE_INY, ITYPE_INX, ITYPE_CLC, ITYPE_SEC, ITYPE_CLI, ITYPE_SEI,
    ITYPE_TYA, ITYPE_CLV, ITYPE_CLD, ITYPE_SED, ITYPE_TXA, ITYPE_TXS, ITYPE_TAX, ITYPE_TSX,
    ITYPE_DEX, ITYPE_NOP
  } itype_e;

  typedef enum logic [2:0] {S_OPC, S_OPR1, S_OPR2, S_ISSUE, S_GAP} dec_state_e;

  typedef struct packed {
    itype_e     itype;
    addr_mode_e mode;
    logic [1:0] size;
  } dec_t;

  // d_to_e_reg layout
  localparam int D2E_W     = 45;
  localparam int D2E_LSB   = 0;
  localparam int D2E_MSB   = 8;
  localparam int D2E_PC    = 16;
  localparam int D2E_MODE  = 32;
  localparam int D2E_SIZE  = 36;
  localparam int D2E_VALID = 38;
  localparam int D2E_TYPE  = 39;

  function automatic logic [1:0] mode_size(input addr_mode_e m);
    case (m)
      ADDR_ACC, ADDR_IMP:                                          return 2'd1;
      ADDR_IMM, ADDR_ZP, ADDR_ZPX, ADDR_REL, ADDR_IZX, ADDR_IZY,
      ADDR_ZPY:                                                    return 2'd2;
      ADDR_ABS, ADDR_ABSX, ADDR_IND, ADDR_ABSY:                    return 2'd3;
      default:                                                     return 2'd0;
    endcase
  endfunction

  // Valid bit is always set: a packed word is only built when issuing.
  function automatic logic [D2E_W-1:0] pack_d2e(input itype_e t, input addr_mode_e m,
      input logic [1:0] s, input logic [15:0] pc, input logic [7:0] msb, input logic [7:0] lsb);
    return {t, 1'b1, s, m, pc, msb, lsb};
  endfunction

  function automatic dec_t decode_op(input logic [7:0] op);
    dec_t       d;
    itype_e     t;
    addr_mode_e m;
    t = ITYPE_ILL;
    m = ADDR_ILL;
    if (op[1:0] == 2'b01) begin
      // ALU group: aaa selects the operation, bbb the addressing mode
      t = itype_e'(6'(op[7:5]) + 6'd1);
      case (op[4:2])
        3'd0: m = ADDR_IZX;  3'd1: m = ADDR_ZP;   3'd2: m = ADDR_IMM;  3'd3: m = ADDR_ABS;
        3'd4: m = ADDR_IZY;  3'd5: m = ADDR_ZPX;  3'd6: m = ADDR_ABSY; default: m = ADDR_ABSX;
      endcase
      if (op == 8'h89) begin
        t = ITYPE_ILL;
        m = ADDR_ILL;
      end
    end else begin
      case (op)
        8'h00: t = ITYPE_BRK;  8'h20: t = ITYPE_JSR;  8'h40: t = ITYPE_RTI;  8'h60: t = ITYPE_RTS;
        8'h08: t = ITYPE_PHP;  8'h28: t = ITYPE_PLP;  8'h48: t = ITYPE_PHA;  8'h68: t = ITYPE_PLA;
        8'h88: t = ITYPE_DEY;  8'hA8: t = ITYPE_TAY;  8'hC8: t = ITYPE_INY;  8'hE8: t = ITYPE_INX;
        8'h18: t = ITYPE_CLC;  8'h38: t = ITYPE_SEC;  8'h58: t = ITYPE_CLI;  8'h78: t = ITYPE_SEI;
        8'h98: t = ITYPE_TYA;  8'hB8: t = ITYPE_CLV;  8'hD8: t = ITYPE_CLD;  8'hF8: t = ITYPE_SED;
        8'h8A: t = ITYPE_TXA;  8'h9A: t = ITYPE_TXS;  8'hAA: t = ITYPE_TAX;  8'hBA: t = ITYPE_TSX;
        8'hCA: t = ITYPE_DEX;  8'hEA: t = ITYPE_NOP;
        8'h10: t = ITYPE_BPL;  8'h30: t = ITYPE_BMI;  8'h50: t = ITYPE_BVC;  8'h70: t = ITYPE_BVS;
        8'h90: t = ITYPE_BCC;  8'hB0: t = ITYPE_BCS;  8'hD0: t = ITYPE_BNE;  8'hF0: t = ITYPE_BEQ;
        8'h06, 8'h0A, 8'h0E, 8'h16, 8'h1E: t = ITYPE_ASL;
        8'h26, 8'h2A, 8'h2E, 8'h36, 8'h3E: t = ITYPE_ROL;
        8'h46, 8'h4A, 8'h4E, 8'h56, 8'h5E: t = ITYPE_LSR;
        8'h66, 8'h6A, 8'h6E, 8'h76, 8'h7E: t = ITYPE_ROR;
        8'h86, 8'h8E, 8'h96:               t = ITYPE_STX;
        8'hA2, 8'hA6, 8'hAE, 8'hB6, 8'hBE: t = ITYPE_LDX;
        8'hC6, 8'hCE, 8'hD6, 8'hDE:        t = ITYPE_DEC;
        8'hE6, 8'hEE, 8'hF6, 8'hFE:        t = ITYPE_INC;
        8'h24, 8'h2C:                      t = ITYPE_BIT;
        8'h4C, 8'h6C:                      t = ITYPE_JMP;
        8'h84, 8'h8C, 8'h94:               t = ITYPE_STY;
        8'hA0, 8'hA4, 8'hAC, 8'hB4, 8'hBC: t = ITYPE_LDY;
        8'hC0, 8'hC4, 8'hCC:               t = ITYPE_CPY;
        8'hE0, 8'hE4, 8'hEC:               t = ITYPE_CPX;
        default:                           t = ITYPE_ILL;
      endcase
      if (t != ITYPE_ILL) begin
        if (op[4:0] == 5'b10000)  m = ADDR_REL;
        else if (op == 8'h20)     m = ADDR_ABS;
        else if (op == 8'h6C)     m = ADDR_IND;
        else if (op[3:0] == 4'h8 || op == 8'h00 || op == 8'h40 || op == 8'h60 ||
                 op == 8'h8A || op == 8'h9A || op == 8'hAA || op == 8'hBA ||
                 op == 8'hCA || op == 8'hEA)
          m = ADDR_IMP;
        else begin
          // RMW / index-register groups share the bbb mode map; X-indexed
          // forms of STX/LDX use Y instead.
          case (op[4:2])
            3'd0:    m = ADDR_IMM;
            3'd1:    m = ADDR_ZP;
            3'd2:    m = ADDR_ACC;
            3'd3:    m = ADDR_ABS;
            3'd5:    m = (op == 8'h96 || op == 8'hB6) ? ADDR_ZPY : ADDR_ZPX;
            3'd7:    m = (op == 8'hBE) ? ADDR_ABSY : ADDR_ABSX;
            default: m = ADDR_ILL;
          endcase
        end
      end
    end
    d.itype = t;
    d.mode  = m;
    d.size  = mode_size(m);
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-byte stream in, decoded word out, plus execute's
// flush/halt controls. master = fetch/execute side, slave = decode stage.
interface decode_stage_if;
  import cpu6502_pkg::*;
  logic [7:0]       fb_data;
  logic [15:0]      fb_pc;
  logic             fb_valid;
  logic             fb_ready;
  logic             flush;
  logic             halt_f_to_d;
  logic             halt_d_to_e;
  logic [D2E_W-1:0] d_to_e_reg;
  logic             illegal_op;

  modport master (output fb_data, fb_pc, fb_valid, flush, halt_f_to_d, halt_d_to_e,
                  input  fb_ready, d_to_e_reg, illegal_op);
  modport slave  (input  fb_data, fb_pc, fb_valid, flush, halt_f_to_d, halt_d_to_e,
                  output fb_ready, d_to_e_reg, illegal_op);
endinterface

// File: rtl/decode_stage_opcode_decoder.sv
// opcode_decoder: combinational opcode -> {instruction type, mode, size}.
//  i_op   in  8  opcode byte
//  o_type out 6  ITYPE_* code (0 = illegal)
//  o_mode out 4  ADDR_* code (0 = illegal)
//  o_size out 2  instruction length in bytes (0 when illegal)
module opcode_decoder
  import cpu6502_pkg::*;
(
  input  logic [7:0] i_op,
  output itype_e     o_type,
  output addr_mode_e o_mode,
  output logic [1:0] o_size
);
  dec_t w_dec;
  assign w_dec  = decode_op(i_op);
  assign o_type = w_dec.itype;
  assign o_mode = w_dec.mode;
  assign o_size = w_dec.size;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: assembles opcode + operand bytes from fetch, decodes them and
// presents one instruction at a time to execute on d_to_e_reg.
//  clk, rst_n  core clock, async active-low reset
//  bus         decode_stage_if.slave: fb_* byte stream, flush, halt_f_to_d,
//              halt_d_to_e, d_to_e_reg (45b), illegal_op (1-cycle pulse)
module decode_stage
  import cpu6502_pkg::*;
#(
  parameter int ISSUE_GAP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  dec_state_e       r_state;
  logic [GW-1:0]    r_gap_cnt;
  itype_e           r_type;
  addr_mode_e       r_mode;
  logic [1:0]       r_size;
  logic [15:0]      r_pc;
  logic [7:0]       r_lsb;
  logic [D2E_W-1:0] r_d2e;
  logic             r_ill;

  itype_e     w_type;
  addr_mode_e w_mode;
  logic [1:0] w_size;
  logic       w_intake;
  logic       w_xfer;

  opcode_decoder u_dec (.i_op(bus.fb_data), .o_type(w_type), .o_mode(w_mode), .o_size(w_size));

  assign w_intake     = (r_state == S_OPC) || (r_state == S_OPR1) || (r_state == S_OPR2);
  // Gated by rst_n so the port reads 0 while reset is held.
  assign bus.fb_ready = rst_n & w_intake & ~bus.halt_f_to_d & ~bus.flush;
  assign w_xfer       = bus.fb_valid & bus.fb_ready;
  assign bus.d_to_e_reg = r_d2e;
  assign bus.illegal_op = r_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OPC;
      r_gap_cnt <= '0;
      r_type    <= ITYPE_ILL;
      r_mode    <= ADDR_ILL;
      r_size    <= 2'd0;
      r_pc      <= 16'h0;
      r_lsb     <= 8'h0;
      r_d2e     <= '0;
      r_ill     <= 1'b0;
    end else begin
      r_ill <= 1'b0;
      if (bus.flush) begin
        // Redirect: drop any partial or issued instruction, no gap needed
        // since valid drops here and the next rise is at least a byte away.
        r_state            <= S_OPC;
        r_d2e[D2E_VALID]   <= 1'b0;
      end else begin
        case (r_state)
          S_OPC: if (w_xfer) begin
            r_type <= w_type;
            r_mode <= w_mode;
            r_size <= w_size;
            r_pc   <= bus.fb_pc;
            if (w_mode == ADDR_ILL) begin
              r_ill <= 1'b1;
            end else if (w_size == 2'd1) begin
              r_d2e   <= pack_d2e(w_type, w_mode, w_size, bus.fb_pc, 8'h00, 8'h00);
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_OPR1;
            end
          end
          S_OPR1: if (w_xfer) begin
            if (r_size == 2'd2) begin
              r_d2e   <= pack_d2e(r_type, r_mode, r_size, r_pc, 8'h00, bus.fb_data);
              r_state <= S_ISSUE;
            end else begin
              r_lsb   <= bus.fb_data;
              r_state <= S_OPR2;
            end
          end
          S_OPR2: if (w_xfer) begin
            r_d2e   <= pack_d2e(r_type, r_mode, r_size, r_pc, bus.fb_data, r_lsb);
            r_state <= S_ISSUE;
          end
          S_ISSUE: if (!bus.halt_d_to_e) begin
            r_d2e[D2E_VALID] <= 1'b0;
            r_gap_cnt        <= GW'(ISSUE_GAP - 1);
            r_state          <= S_GAP;
          end
          S_GAP: begin
            if (r_gap_cnt == '0) r_state <= S_OPC;
            else                 r_gap_cnt <= r_gap_cnt - 1'b1;
          end
          default: r_state <= S_OPC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage #(.ISSUE_GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  bit prev_v   = 1'b0;
  logic [44:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [44:0] mkw(input logic [5:0] t, input logic [3:0] m,
      input logic [1:0] s, input logic [15:0] pc, input logic [7:0] msb, input logic [7:0] lsb);
    return {t, 1'b1, s, m, pc, msb, lsb};
  endfunction

  // Scoreboard: every rising edge of the valid bit must match the oldest
  // expected word, one cycle after the last byte was presented.
  always @(negedge clk) begin
    logic [44:0] exp_w;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (bus.d_to_e_reg[38] && !prev_v) begin
        rise_cyc = cyc;
        check("issue_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          check("d2e_word", 64'(bus.d_to_e_reg), 64'(exp_w));
          check("issue_latency", 64'(cyc - last_acc), 64'd1);
        end
      end
      if (!bus.d_to_e_reg[38] && prev_v) fall_cyc = cyc;
      prev_v = bus.d_to_e_reg[38];
    end
  end

  // Starts and ends on a falling edge; records the cycle the byte was presented.
  task automatic send(input logic [7:0] d, input logic [15:0] pc);
    int  n = 0;
    bit  done = 1'b0;
    bus.fb_valid = 1'b1;
    bus.fb_data  = d;
    bus.fb_pc    = pc;
    while (!done) begin
      #1;
      if (bus.fb_ready) begin
        last_acc = cyc;
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
        if (n > 100) begin
          check("send_timeout", 64'(bus.fb_ready), 64'd1);
          done = 1'b1;
        end
      end
    end
    bus.fb_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          n;
    logic [15:0] pc;
    logic [5:0]  t;
    logic [3:0]  m;
    logic [1:0]  s;
    logic [7:0]  lsb, msb;
    bit          ill;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{8'h09, 8'h55, 8'h00, 2, 16'h8000, 6'd1,  4'd2,  2'd2, 8'h55, 8'h00, 1'b0};
    vt[1]  = '{8'h0D, 8'h34, 8'h12, 3, 16'h8002, 6'd1,  4'd3,  2'd3, 8'h34, 8'h12, 1'b0};
    vt[2]  = '{8'hEA, 8'h00, 8'h00, 1, 16'h8005, 6'd56, 4'd7,  2'd1, 8'h00, 8'h00, 1'b0};
    vt[3]  = '{8'h0A, 8'h00, 8'h00, 1, 16'h8006, 6'd9,  4'd1,  2'd1, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{8'hB1, 8'h10, 8'h00, 2, 16'h8007, 6'd6,  4'd10, 2'd2, 8'h10, 8'h00, 1'b0};
    vt[5]  = '{8'hBE, 8'h00, 8'h20, 3, 16'h8009, 6'd14, 4'd13, 2'd3, 8'h00, 8'h20, 1'b0};
    vt[6]  = '{8'h96, 8'h44, 8'h00, 2, 16'h800C, 6'd13, 4'd12, 2'd2, 8'h44, 8'h00, 1'b0};
    vt[7]  = '{8'h6C, 8'h00, 8'h30, 3, 16'h800E, 6'd18, 4'd11, 2'd3, 8'h00, 8'h30, 1'b0};
    vt[8]  = '{8'hD0, 8'hFE, 8'h00, 2, 16'h8011, 6'd29, 4'd8,  2'd2, 8'hFE, 8'h00, 1'b0};
    vt[9]  = '{8'h20, 8'h00, 8'hC0, 3, 16'h8013, 6'd32, 4'd3,  2'd3, 8'h00, 8'hC0, 1'b0};
    vt[10] = '{8'h7D, 8'h01, 8'h02, 3, 16'h8016, 6'd4,  4'd6,  2'd3, 8'h01, 8'h02, 1'b0};
    vt[11] = '{8'h89, 8'h00, 8'h00, 1, 16'h8019, 6'd0,  4'd0,  2'd0, 8'h00, 8'h00, 1'b1};
    vt[12] = '{8'h02, 8'h00, 8'h00, 1, 16'h801A, 6'd0,  4'd0,  2'd0, 8'h00, 8'h00, 1'b1};
    vt[13] = '{8'h95, 8'h10, 8'h00, 2, 16'h801B, 6'd5,  4'd5,  2'd2, 8'h10, 8'h00, 1'b0};
    vt[14] = '{8'hE1, 8'h22, 8'h00, 2, 16'h801D, 6'd8,  4'd9,  2'd2, 8'h22, 8'h00, 1'b0};
    vt[15] = '{8'hA9, 8'h7F, 8'h00, 2, 16'h801F, 6'd6,  4'd2,  2'd2, 8'h7F, 8'h00, 1'b0};
    vt[16] = '{8'h4C, 8'h00, 8'h80, 3, 16'h8021, 6'd18, 4'd3,  2'd3, 8'h00, 8'h80, 1'b0};
    vt[17] = '{8'h48, 8'h00, 8'h00, 1, 16'h8024, 6'd37, 4'd7,  2'd1, 8'h00, 8'h00, 1'b0};

    bus.fb_valid = 1'b0; bus.fb_data = 8'h00; bus.fb_pc = 16'h0000;
    bus.flush = 1'b0; bus.halt_f_to_d = 1'b0; bus.halt_d_to_e = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_d2e", 64'(bus.d_to_e_reg), 64'd0);
    check("rst_fb_ready", 64'(bus.fb_ready), 64'd0);
    check("rst_illegal", 64'(bus.illegal_op), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", 64'(bus.fb_ready), 64'd1);
    @(negedge clk);

    // Decode table
    for (int i = 0; i < 18; i++) begin
      if (!vt[i].ill) sb.push_back(mkw(vt[i].t, vt[i].m, vt[i].s, vt[i].pc, vt[i].msb, vt[i].lsb));
      send(vt[i].b0, vt[i].pc);
      if (vt[i].n > 1) send(vt[i].b1, vt[i].pc + 16'd1);
      if (vt[i].n > 2) send(vt[i].b2, vt[i].pc + 16'd2);
      if (vt[i].ill) begin
        check("illegal_pulse", 64'(bus.illegal_op), 64'd1);
        @(negedge clk);
        check("illegal_clear", 64'(bus.illegal_op), 64'd0);
      end
    end

    // Execute holds the word for 5 cycles; halt raised before issue is harmless
    sb.push_back(mkw(6'd1, 4'd9, 2'd2, 16'h9000, 8'h00, 8'h20));
    send(8'h01, 16'h9000);
    bus.halt_d_to_e = 1'b1;
    send(8'h20, 16'h9001);
    for (int k = 0; k < 5; k++) begin
      check("halt_word_stable", 64'(bus.d_to_e_reg), 64'(mkw(6'd1, 4'd9, 2'd2, 16'h9000, 8'h00, 8'h20)));
      check("halt_no_intake", 64'(bus.fb_ready), 64'd0);
      if (k == 4) bus.halt_d_to_e = 1'b0;
      @(negedge clk);
    end
    check("halt_release_gap", 64'(bus.d_to_e_reg[38]), 64'd0);
    check("gap_no_intake", 64'(bus.fb_ready), 64'd0);

    // Back-to-back: valid low for the gap plus the single-byte NOP intake cycle
    sb.push_back(mkw(6'd1, 4'd3, 2'd3, 16'h9100, 8'h12, 8'h34));
    send(8'h0D, 16'h9100); send(8'h34, 16'h9101); send(8'h12, 16'h9102);
    sb.push_back(mkw(6'd56, 4'd7, 2'd1, 16'h9103, 8'h00, 8'h00));
    send(8'hEA, 16'h9103);
    @(negedge clk);
    check("valid_low_cycles", 64'(rise_cyc - fall_cyc), 64'(GAP + 1));

    // halt_f_to_d mid-instruction stalls intake but keeps partial bytes
    sb.push_back(mkw(6'd1, 4'd3, 2'd3, 16'hC000, 8'h12, 8'h34));
    send(8'h0D, 16'hC000);
    bus.halt_f_to_d = 1'b1;
    bus.fb_valid = 1'b1; bus.fb_data = 8'h34; bus.fb_pc = 16'hC001;
    repeat (3) begin
      #1 check("halt_f_ready", 64'(bus.fb_ready), 64'd0);
      @(negedge clk);
    end
    bus.halt_f_to_d = 1'b0;
    bus.fb_valid = 1'b0;
    send(8'h34, 16'hC001); send(8'h12, 16'hC002);

    // Flush mid-instruction: partial ORA abs dropped, EA is a fresh opcode
    send(8'h0D, 16'hA000); send(8'h34, 16'hA001);
    bus.flush = 1'b1;
    #1 check("flush_ready", 64'(bus.fb_ready), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_no_valid", 64'(bus.d_to_e_reg[38]), 64'd0);
    #1 check("flush_to_opc", 64'(bus.fb_ready), 64'd1);
    @(negedge clk);
    sb.push_back(mkw(6'd56, 4'd7, 2'd1, 16'hA010, 8'h00, 8'h00));
    send(8'hEA, 16'hA010);

    // Async reset mid-OPR2, asserted between clock edges
    repeat (3) @(negedge clk);
    send(8'h0D, 16'hB000); send(8'h34, 16'hB001);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d2e", 64'(bus.d_to_e_reg), 64'd0);
    check("async_rst_ready", 64'(bus.fb_ready), 64'd0);
    check("async_rst_illegal", 64'(bus.illegal_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(mkw(6'd56, 4'd7, 2'd1, 16'hB100, 8'h00, 8'h00));
    send(8'hEA, 16'hB100);
    sb.push_back(mkw(6'd6, 4'd2, 2'd2, 16'hB101, 8'h00, 8'h7F));
    send(8'hA9, 16'hB101); send(8'h7F, 16'hB102);

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
